// File: rtl/slip_io_pkg.sv
// Shared types and defaults for the Slipstream I/O strobe sequencer.
// Holds the sequencer state encoding and the setup/hold counter width.
package slip_io_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETUP  = 3'd1,
      ACTIVE = 3'd2,
      HOLD   = 3'd3,
      DONE   = 3'd4
   } io_seq_state_t;

   localparam int SETUP_CYC_DEF = 1;
   localparam int HOLD_CYC_DEF  = 1;
   localparam int WAIT_W_DEF    = 4;

   // SETUP_CYC and HOLD_CYC never exceed 3, so two bits cover both phases.
   localparam int SH_CNT_W = 2;

endpackage

// File: rtl/io_down_counter.sv
// Loadable, non-wrapping down-counter with a zero flag.
// Load has priority over decrement; the count parks at zero.
module io_down_counter #(
   parameter int W = 2
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_dec,
   output logic         o_zero
);

   logic [W-1:0] r_count;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_dec && (r_count != '0)) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign o_zero = (r_count == '0);

endmodule

// File: rtl/io_cycle_sequencer.sv
// Turns a decoded bus request into a setup/active/hold strobe sequence with a ready pulse.
// Optional feature macro: IO_WAIT_EXTEND_EN (ext_wait stretches the last ACTIVE cycle).
module io_cycle_sequencer
   import slip_io_pkg::*;
#(
   parameter int SETUP_CYC = SETUP_CYC_DEF,
   parameter int HOLD_CYC  = HOLD_CYC_DEF,
   parameter int WAIT_W    = WAIT_W_DEF
) (
   input  logic              MasterClock,
   input  logic              reset,
   input  logic              decode_hit,
   input  logic              req,
   input  logic              wr,
   input  logic [WAIT_W-1:0] wait_cnt,
   input  logic              ext_wait,
   output logic              rd_strobe,
   output logic              wr_strobe,
   output logic              busy,
   output logic              ready,
   output logic [2:0]        o_dbg_state
);

   localparam logic [SH_CNT_W-1:0] SETUP_LD = SH_CNT_W'(SETUP_CYC - 1);
   localparam logic [SH_CNT_W-1:0] HOLD_LD  = SH_CNT_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

   io_seq_state_t     r_state;
   logic              r_rd_strobe;
   logic              r_wr_strobe;
   logic              r_busy;
   logic              r_ready;
   logic              r_wr_cap;
   logic [WAIT_W-1:0] r_wait_cap;

   logic                w_accept;
   logic                w_active_end;
   logic                w_ext_hold;
   logic                w_sh_load;
   logic [SH_CNT_W-1:0] w_sh_val;
   logic                w_sh_dec;
   logic                w_sh_zero;
   logic                w_act_load;
   logic                w_act_dec;
   logic                w_act_zero;

`ifdef IO_WAIT_EXTEND_EN
   assign w_ext_hold = ext_wait;
`else
   logic w_unused_ext;
   assign w_unused_ext = ext_wait;
   assign w_ext_hold   = 1'b0;
`endif

   // One counter serves both SETUP and HOLD since those phases never overlap.
   always_comb begin
      w_accept     = (r_state == IDLE) && req && decode_hit;
      w_active_end = (r_state == ACTIVE) && w_act_zero && !w_ext_hold;
      w_sh_load    = w_accept || (w_active_end && (HOLD_CYC > 0));
      w_sh_val     = w_accept ? SETUP_LD : HOLD_LD;
      w_sh_dec     = (r_state == SETUP) || (r_state == HOLD);
      w_act_load   = (r_state == SETUP) && w_sh_zero;
      w_act_dec    = (r_state == ACTIVE);
   end

   io_down_counter #(.W(SH_CNT_W)) u_sh_cnt (
      .i_clk      (MasterClock),
      .i_reset    (reset),
      .i_load     (w_sh_load),
      .i_load_val (w_sh_val),
      .i_dec      (w_sh_dec),
      .o_zero     (w_sh_zero)
   );

   io_down_counter #(.W(WAIT_W)) u_act_cnt (
      .i_clk      (MasterClock),
      .i_reset    (reset),
      .i_load     (w_act_load),
      .i_load_val (r_wait_cap),
      .i_dec      (w_act_dec),
      .o_zero     (w_act_zero)
   );

   always_ff @(posedge MasterClock) begin
      if (reset) begin
         r_state     <= IDLE;
         r_rd_strobe <= 1'b0;
         r_wr_strobe <= 1'b0;
         r_busy      <= 1'b0;
         r_ready     <= 1'b0;
         r_wr_cap    <= 1'b0;
         r_wait_cap  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_wr_cap   <= wr;
                  r_wait_cap <= wait_cnt;
                  r_busy     <= 1'b1;
                  r_state    <= SETUP;
               end
            end
            SETUP: begin
               if (w_sh_zero) begin
                  r_rd_strobe <= !r_wr_cap;
                  r_wr_strobe <= r_wr_cap;
                  r_state     <= ACTIVE;
               end
            end
            ACTIVE: begin
               if (w_active_end) begin
                  r_rd_strobe <= 1'b0;
                  r_wr_strobe <= 1'b0;
                  if (HOLD_CYC > 0) begin
                     r_state <= HOLD;
                  end else begin
                     r_ready <= 1'b1;
                     r_state <= DONE;
                  end
               end
            end
            HOLD: begin
               if (w_sh_zero) begin
                  r_ready <= 1'b1;
                  r_state <= DONE;
               end
            end
            DONE: begin
               r_ready <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign rd_strobe   = r_rd_strobe;
   assign wr_strobe   = r_wr_strobe;
   assign busy        = r_busy;
   assign ready       = r_ready;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_io_cycle_sequencer.sv
// Self-checking bench for io_cycle_sequencer: default instance (HOLD_CYC=1) and a HOLD_CYC=0 instance.
// Expected strobe timing per transaction is queued at drive time and compared when ready is seen.
module tb_io_cycle_sequencer;

   localparam int SETUP = 1;

   logic       clk;
   logic       reset;
   logic       ext_wait;
   logic       sel_b;

   logic       a_req, a_hit, a_wr;
   logic [3:0] a_wait;
   logic       a_rd, a_wrs, a_busy, a_ready;
   logic [2:0] a_state;

   logic       b_req, b_hit, b_wr;
   logic [3:0] b_wait;
   logic       b_rd, b_wrs, b_busy, b_ready;
   logic [2:0] b_state;

   logic       m_rd, m_wrs, m_busy, m_ready;

   int errors;
   int checks;
   logic [55:0] exp_q[$];

   io_cycle_sequencer u_dut_a (
      .MasterClock (clk),
      .reset       (reset),
      .decode_hit  (a_hit),
      .req         (a_req),
      .wr          (a_wr),
      .wait_cnt    (a_wait),
      .ext_wait    (ext_wait),
      .rd_strobe   (a_rd),
      .wr_strobe   (a_wrs),
      .busy        (a_busy),
      .ready       (a_ready),
      .o_dbg_state (a_state)
   );

   io_cycle_sequencer #(.HOLD_CYC(0)) u_dut_b (
      .MasterClock (clk),
      .reset       (reset),
      .decode_hit  (b_hit),
      .req         (b_req),
      .wr          (b_wr),
      .wait_cnt    (b_wait),
      .ext_wait    (ext_wait),
      .rd_strobe   (b_rd),
      .wr_strobe   (b_wrs),
      .busy        (b_busy),
      .ready       (b_ready),
      .o_dbg_state (b_state)
   );

   assign m_rd    = sel_b ? b_rd    : a_rd;
   assign m_wrs   = sel_b ? b_wrs   : a_wrs;
   assign m_busy  = sel_b ? b_busy  : a_busy;
   assign m_ready = sel_b ? b_ready : a_ready;

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // driver tasks
   task automatic set_req(input logic r, input logic h, input logic w, input logic [3:0] wc);
      if (sel_b) begin
         b_req = r; b_hit = h; b_wr = w; b_wait = wc;
      end else begin
         a_req = r; a_hit = h; a_wr = w; a_wait = wc;
      end
   endtask

   // Drives one accepted request at the current negedge and scoreboards its strobe timing.
   task automatic run_txn(input logic t_wr, input logic [3:0] t_wait, input int ext_len,
                          input bit keep_req, input string name);
      int lat, first, rd_w, wr_w, busy_c, rdy_c, both_c, fz, hold, width;
      logic [55:0] exp_v, obs_v;
      width = int'(t_wait) + 1;
`ifdef IO_WAIT_EXTEND_EN
      width = width + ext_len;
`endif
      hold  = sel_b ? 0 : 1;
      exp_v = {8'(SETUP + 1), (t_wr ? 8'(width) : 8'd0), (t_wr ? 8'd0 : 8'(width)),
               8'(SETUP + width + hold + 1), 8'(SETUP + width + hold + 1), 8'd1, 8'd0};
      exp_q.push_back(exp_v);
      set_req(1'b1, 1'b1, t_wr, t_wait);
      fz = SETUP + 1 + int'(t_wait);
      lat = 0; first = 0; rd_w = 0; wr_w = 0; busy_c = 0; rdy_c = 0; both_c = 0;
      for (int c = 1; c <= 300; c++) begin
         @(negedge clk);
         if ((m_rd || m_wrs) && first == 0) first = c;
         rd_w   += int'(m_rd);
         wr_w   += int'(m_wrs);
         busy_c += int'(m_busy);
         rdy_c  += int'(m_ready);
         both_c += int'(m_rd && m_wrs);
         if (m_ready && lat == 0) lat = c;
         if (lat != 0 && c == lat + 1) break;
         ext_wait = (ext_len > 0) && (c >= fz) && (c < fz + ext_len);
         if (lat != 0 && keep_req)
            set_req(1'b1, 1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
         else
            set_req(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    4'($urandom_range(0, 15)));
      end
      ext_wait = 1'b0;
      checks++;
      if (lat == 0) begin
         errors++;
         void'(exp_q.pop_front());
         $display("FAIL %s: no ready within 300 cycles", name);
      end else begin
         exp_v = exp_q.pop_front();
         obs_v = {8'(first), 8'(wr_w), 8'(rd_w), 8'(lat), 8'(busy_c), 8'(rdy_c), 8'(both_c)};
         if (obs_v !== exp_v) begin
            errors++;
            $display("FAIL %s: got first/wr/rd/lat/busy/rdy/both=%h expected %h", name, obs_v, exp_v);
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      sel_b = 1'b0; set_req(1'b1, 1'b1, 1'b1, 4'd3);
      sel_b = 1'b1; set_req(1'b1, 1'b1, 1'b0, 4'd2);
      sel_b = 1'b0;
      ext_wait = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if ({a_rd, a_wrs, a_busy, a_ready, a_state, b_rd, b_wrs, b_busy, b_ready, b_state} !== 14'd0) begin
            errors++;
            $display("FAIL reset_state: a=%b%b%b%b/%0d b=%b%b%b%b/%0d expected all zero",
                     a_rd, a_wrs, a_busy, a_ready, a_state, b_rd, b_wrs, b_busy, b_ready, b_state);
         end
      end
      sel_b = 1'b1; set_req(1'b0, 1'b0, 1'b0, 4'd0);
      sel_b = 1'b0; set_req(1'b0, 1'b0, 1'b0, 4'd0);
      ext_wait = 1'b0;
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_read();
      sel_b = 1'b0;
      run_txn(1'b0, 4'd2, 0, 1'b0, "read_wait2");
   endtask

   task automatic test_write_nohold();
      sel_b = 1'b1;
      run_txn(1'b1, 4'd0, 0, 1'b0, "write_wait0_hold0");
      run_txn(1'b0, 4'd3, 0, 1'b0, "read_wait3_hold0");
      sel_b = 1'b0;
   endtask

   task automatic test_no_hit();
      sel_b = 1'b0;
      set_req(1'b1, 1'b0, 1'b1, 4'd1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if ({a_rd, a_wrs, a_busy, a_ready, a_state} !== 7'd0) begin
            errors++;
            $display("FAIL no_hit_idle: outputs=%b%b%b%b state=%0d expected 0", a_rd, a_wrs, a_busy, a_ready, a_state);
         end
      end
      run_txn(1'b1, 4'd1, 0, 1'b0, "hit_after_miss");
   endtask

   task automatic test_reset_mid();
      logic rd3;
      int rdy_c;
      sel_b = 1'b0;
      rd3 = 1'b0;
      rdy_c = 0;
      set_req(1'b1, 1'b1, 1'b0, 4'd5);
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         rdy_c += int'(a_ready);
         if (c == 3) begin
            rd3 = a_rd;
            reset = 1'b1;
         end
         if (c == 1) set_req(1'b0, 1'b1, 1'b1, 4'd9);
      end
      checks++;
      if (rd3 !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_strobe_before: rd_strobe=%b expected 1", rd3);
      end
      checks++;
      if ({a_rd, a_wrs, a_busy, a_ready, a_state, 8'(rdy_c)} !== 15'd0) begin
         errors++;
         $display("FAIL reset_mid_abort: rd=%b wr=%b busy=%b ready=%b state=%0d readies=%0d expected all 0",
                  a_rd, a_wrs, a_busy, a_ready, a_state, rdy_c);
      end
      reset = 1'b0;
      run_txn(1'b1, 4'd1, 0, 1'b0, "after_reset");
   endtask

   task automatic test_max_wait();
      sel_b = 1'b0;
      run_txn(1'b0, 4'd15, 0, 1'b0, "read_wait15");
      run_txn(1'b1, 4'd15, 0, 1'b0, "write_wait15");
   endtask

   task automatic test_ext_wait();
      sel_b = 1'b0;
      run_txn(1'b0, 4'd2, 3, 1'b0, "ext_wait3_read");
      run_txn(1'b1, 4'd0, 2, 1'b0, "ext_wait2_write");
   endtask

   task automatic test_back_to_back();
      sel_b = 1'b0;
      for (int i = 0; i < 6; i++)
         run_txn(1'($urandom_range(0, 1)), 4'($urandom_range(0, 6)), 0, (i < 5), "back_to_back_a");
      sel_b = 1'b1;
      for (int i = 0; i < 4; i++)
         run_txn(1'($urandom_range(0, 1)), 4'($urandom_range(0, 6)), 0, (i < 3), "back_to_back_b");
      sel_b = 1'b0;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      sel_b = 1'b0;
      ext_wait = 1'b0;
      reset = 1'b1;
      a_req = 1'b0; a_hit = 1'b0; a_wr = 1'b0; a_wait = 4'd0;
      b_req = 1'b0; b_hit = 1'b0; b_wr = 1'b0; b_wait = 4'd0;
      test_reset();
      test_read();
      test_write_nohold();
      test_no_hit();
      test_reset_mid();
      test_max_wait();
      test_ext_wait();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/io_cycle_sequencer.md
Name: io_cycle_sequencer

Overview:
- Consumes the registered output of the 6-input AND address/qualifier decode: one "decode hit" per device select.
- Converts a qualified CPU bus request into a timed I/O strobe sequence (setup, active, hold) with a ready handshake back to the bus master.
- Sits directly downstream of the decode AND stage and upstream of the peripheral read/write strobe pins in Slipstream.

Parameters:
- SETUP_CYC, 1, cycles of address setup before the strobe asserts (1..3).
- HOLD_CYC, 1, cycles of address hold after the strobe deasserts (0..3).
- WAIT_W, 4, width of the programmable active-phase wait count.

Ports:
- MasterClock  in  1  single system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- decode_hit  in  1  output of the 6-input AND decode; high means the current address selects this device.
- req  in  1  bus request, level; sampled only in IDLE.
- wr  in  1  1 = write cycle, 0 = read cycle; captured with req.
- wait_cnt  in  WAIT_W  active-phase length minus one; captured at cycle start.
- ext_wait  in  1  peripheral wait input (used only with IO_WAIT_EXTEND_EN).
- rd_strobe  out  1  active-high read strobe to the peripheral.
- wr_strobe  out  1  active-high write strobe to the peripheral.
- busy  out  1  high from cycle acceptance until DONE completes.
- ready  out  1  one-cycle pulse that ends the bus cycle.

Behaviour:
- Reset (synchronous, any state): state = IDLE; rd_strobe, wr_strobe, busy, ready = 0; counters = 0.
- All outputs are registered. No combinational path exists from any input to any output.
- States: IDLE, SETUP, ACTIVE, HOLD, DONE.
- IDLE:
  - If req & decode_hit: capture wr and wait_cnt, load setup counter with SETUP_CYC-1, set busy = 1, go to SETUP.
  - If req & !decode_hit: stay in IDLE. The request belongs to another device.
- SETUP: count down; at 0, go to ACTIVE and load the active counter with the captured wait_cnt.
- ACTIVE:
  - rd_strobe = !wr_cap or wr_strobe = wr_cap for every ACTIVE cycle; the two strobes are never high together.
  - Lasts wait_cnt+1 cycles.
  - At count 0: go to HOLD if HOLD_CYC > 0, else go to DONE.
- HOLD: strobes low; lasts HOLD_CYC cycles, then go to DONE.
- DONE: ready = 1 for exactly one cycle; busy deasserts on the following edge; go to IDLE.
- A new cycle may be accepted on the cycle after DONE, never in DONE itself.
- Total latency, req&hit sampled to ready high: SETUP_CYC + (wait_cnt+1) + HOLD_CYC + 1 cycles.
- decode_hit, req and wait_cnt changing after acceptance have no effect; the cycle always runs to completion.
- wait_cnt = 0 gives a 1-cycle strobe. wait_cnt = all-ones gives 2^WAIT_W cycles. Counters do not wrap.
- Reset asserted mid-cycle aborts immediately: strobes drop the same edge, no ready pulse is issued.

Optional Feature:
- Macro: IO_WAIT_EXTEND_EN.
- Defined:
  - In ACTIVE at count 0, ext_wait = 1 holds the state and the strobe, one cycle per cycle ext_wait stays high.
  - Exit occurs on the first edge that sees count 0 and ext_wait = 0.
  - ext_wait is ignored in all other states.
- Undefined: the ext_wait port still exists but is ignored; timing is fixed by wait_cnt alone.

Decomposition:
- Shared package slip_io_pkg holds:
  - state enum io_seq_state_t (IDLE, SETUP, ACTIVE, HOLD, DONE);
  - localparam defaults for SETUP_CYC, HOLD_CYC, WAIT_W;
  - helper localparam for the setup/hold counter width, 2 bits.
- One sub-module is natural: io_down_counter, a loadable down-counter with a zero flag, instanced once for setup/hold and once for active.

Test Plan:
- Read, defaults, wait_cnt = 2: req = 1, hit = 1, wr = 0 at cycle 0 -> rd_strobe high cycles 2-4, wr_strobe never high, ready pulses at cycle 6, busy high cycles 1-6.
- Write, wait_cnt = 0, HOLD_CYC = 0: -> wr_strobe high for exactly 1 cycle, ready on the next cycle, total latency 3.
- req = 1, hit = 0 for 10 cycles -> stays in IDLE, all outputs 0; then hit = 1 -> cycle starts on the next edge.
- Reset asserted on the 2nd ACTIVE cycle, wait_cnt = 5 -> strobe low and busy low on the next edge, no ready pulse, back-to-back req accepted after reset releases.
- wait_cnt = 15 (WAIT_W = 4) -> strobe width of exactly 16 cycles, no wrap.
- IO_WAIT_EXTEND_EN, ext_wait held high for 3 cycles at ACTIVE count 0 -> strobe width = wait_cnt+1+3; with the macro undefined, width = wait_cnt+1.
